// File: rtl/eth_tx_framer.sv
// eth_tx_framer: transmit frame builder feeding the mac_rgmii TX inputs.
// Prepends a fixed Ethernet header (DST_MAC, SRC_MAC, ETHERTYPE) to a
// user payload. Zero-pads short payloads to a 60-byte frame. Inserts
// IFG_CYCLES idle cycles after each frame.
// Ports:
//   mac_tx_clk / mac_tx_rstn : clock, async active-low reset
//   start_i, len_i           : frame request and payload length (1..1500)
//   pld_data_i/valid_i/ready_o : payload byte stream, one slot per ready
//   mac_tx_data/valid/sof/eof : frame byte stream to the MAC
//   busy_o, done_o, err_o, underrun_o : status and pulses
module eth_tx_framer #(
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic        mac_tx_clk,
  input  logic        mac_tx_rstn,
  input  logic        start_i,
  input  logic [10:0] len_i,
  input  logic [7:0]  pld_data_i,
  input  logic        pld_valid_i,
  output logic        pld_ready_o,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_valid,
  output logic        mac_tx_sof,
  output logic        mac_tx_eof,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        underrun_o
);

  localparam int unsigned LEN_W   = 11;
  localparam int unsigned GAP_W   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [LEN_W-1:0] HDR_LEN  = LEN_W'(14);
  localparam logic [LEN_W-1:0] PAD_LEN  = LEN_W'(46);
  localparam logic [LEN_W-1:0] MIN_LAST = LEN_W'(59);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(1500);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);
  localparam logic [111:0]     HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PLD  = 3'd2,
    S_PAD  = 3'd3,
    S_GAP  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;    // index of the byte on mac_tx_data
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  last_q, last_d;  // index of the eof byte
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       sof_q, sof_d;
  logic       eof_q, eof_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       und_q, und_d;

  logic             len_ok;
  logic [LEN_W-1:0] nxt;
  logic [LEN_W-1:0] pld_last;
  logic [6:0]       hsh;
  logic [7:0]       hdr_byte;

  assign len_ok   = (len_i != '0) && (len_i <= MAX_LEN);
  assign nxt      = cnt_q + LEN_W'(1);
  assign pld_last = (HDR_LEN - LEN_W'(1)) + len_q;

  // State and counter registers
  always_ff @(posedge mac_tx_clk or negedge mac_tx_rstn) begin
    if (!mac_tx_rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      last_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state: segment of the next frame byte, gap countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    last_d  = last_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && len_ok) begin
          state_d = S_HDR;
          cnt_d   = '0;
          len_d   = len_i;
          last_d  = (len_i < PAD_LEN) ? MIN_LAST : (HDR_LEN - LEN_W'(1)) + len_i;
        end
      end
      S_HDR, S_PLD, S_PAD: begin
        if (cnt_q == last_q) begin
          state_d = S_GAP;
          cnt_d   = '0;
          gap_d   = '0;
        end else begin
          cnt_d = nxt;
          if (nxt < HDR_LEN)        state_d = S_HDR;
          else if (nxt <= pld_last) state_d = S_PLD;
          else                      state_d = S_PAD;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Header byte for the next frame index (valid for indices 0..13)
  always_comb begin
    hsh      = {4'(4'd13 - cnt_d[3:0]), 3'b000};
    hdr_byte = 8'(HDR >> hsh);
  end

  // Output decode: values for the next cycle, registered below
  always_comb begin
    data_d  = '0;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    und_d   = 1'b0;

    err_d   = (state_q == S_IDLE) && start_i && !len_ok;
    valid_d = (state_d == S_HDR) || (state_d == S_PLD) || (state_d == S_PAD);
    busy_d  = (state_d != S_IDLE);
    sof_d   = (state_q == S_IDLE) && (state_d == S_HDR);
    eof_d   = valid_d && (cnt_d == last_d);
    done_d  = (state_q != S_GAP) && (state_d == S_GAP);
    // Ready one cycle ahead of each payload byte so it lands on the wire next
    ready_d = valid_d && (cnt_d >= (HDR_LEN - LEN_W'(1))) &&
              (cnt_d <= (HDR_LEN - LEN_W'(2)) + len_d);
    // A payload slot is always consumed; a missing byte becomes 0x00
    und_d   = ready_q && !pld_valid_i;
    if (state_d == S_HDR)                   data_d = hdr_byte;
    else if (ready_q && pld_valid_i)        data_d = pld_data_i;
  end

  // Output registers
  always_ff @(posedge mac_tx_clk or negedge mac_tx_rstn) begin
    if (!mac_tx_rstn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      und_q   <= und_d;
    end
  end

  assign mac_tx_data  = data_q;
  assign mac_tx_valid = valid_q;
  assign mac_tx_sof   = sof_q;
  assign mac_tx_eof   = eof_q;
  assign pld_ready_o  = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign underrun_o   = und_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: stimulus pushes expected frame bytes,
// a negedge monitor pops and compares every byte the DUT presents.
module tb_eth_tx_framer;

  localparam int IFG = 12;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [10:0] len_i;
  logic [7:0] pld_data_i;
  logic       pld_valid_i;
  logic       pld_ready_o;
  logic [7:0] mac_tx_data;
  logic       mac_tx_valid, mac_tx_sof, mac_tx_eof;
  logic       busy_o, done_o, err_o, underrun_o;

  eth_tx_framer dut (
    .mac_tx_clk  (clk),
    .mac_tx_rstn (rst_n),
    .start_i     (start_i),
    .len_i       (len_i),
    .pld_data_i  (pld_data_i),
    .pld_valid_i (pld_valid_i),
    .pld_ready_o (pld_ready_o),
    .mac_tx_data (mac_tx_data),
    .mac_tx_valid(mac_tx_valid),
    .mac_tx_sof  (mac_tx_sof),
    .mac_tx_eof  (mac_tx_eof),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .underrun_o  (underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       und;
  } exp_t;

  exp_t q[$];
  int   sof_t[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   byte_idx = 0;
  int   und_cnt = 0;
  int   slot = 0;
  int   rdy_cnt = 0;
  int   take_cnt = 0;
  logic prev_eof = 1'b0;

  logic [7:0] pay_mem [0:2047];
  bit         vld_mem [0:2047];
  logic [7:0] hdr_b [0:13] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                               8'h88, 8'hB5};

  wire [15:0] outs = {pld_ready_o, mac_tx_data, mac_tx_valid, mac_tx_sof,
                      mac_tx_eof, busy_o, done_o, err_o, underrun_o};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Payload source: presents slot data each cycle, advances on a ready cycle
  initial begin
    pld_data_i  = '0;
    pld_valid_i = 1'b0;
    forever begin
      @(negedge clk);
      pld_data_i  = pay_mem[slot];
      pld_valid_i = vld_mem[slot];
      if (pld_ready_o) begin
        rdy_cnt++;
        if (vld_mem[slot]) take_cnt++;
        slot++;
      end
    end
  end

  // Monitor / scoreboard checker
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mac_tx_valid) begin
      if (mac_tx_sof) byte_idx = 0;
      if (q.size() == 0) begin
        chk("unexpected_byte", 32'(mac_tx_data), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk($sformatf("byte%0d{d,sof,eof,und}", byte_idx),
            32'({mac_tx_data, mac_tx_sof, mac_tx_eof, underrun_o}),
            32'({e.d, e.sof, e.eof, e.und}));
      end
      byte_idx++;
    end else if (underrun_o) begin
      chk("underrun_outside_frame", 32'(underrun_o), 32'(0));
    end
    if (mac_tx_sof) sof_t.push_back(cyc);
    if (underrun_o) und_cnt++;
    if (done_o) chk("done_after_eof", 32'(prev_eof), 32'(1));
    prev_eof = mac_tx_eof;
  end

  task automatic push_frame(input int len, input int base, input int nbytes);
    int f;
    f = 14 + ((len < 46) ? 46 : len);
    for (int i = 0; i < f && i < nbytes; i++) begin
      exp_t e;
      e.sof = (i == 0);
      e.eof = (i == f - 1);
      e.und = 1'b0;
      if (i < 14) e.d = hdr_b[i];
      else if (i < 14 + len) begin
        if (vld_mem[base + i - 14]) e.d = pay_mem[base + i - 14];
        else begin
          e.d   = 8'h00;
          e.und = 1'b1;
        end
      end else e.d = 8'h00;
      q.push_back(e);
    end
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    start_i = 1'b1;
    len_i   = 11'(len);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Waits for done, then checks the gap length through busy_o
  task automatic wait_done(input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #1;
      if (done_o) begin
        got = 1'b1;
        break;
      end
    end
    chk({nm, "_done_seen"}, 32'(got), 32'(1));
    chk({nm, "_queue_drained"}, 32'(q.size()), 32'(0));
    repeat (IFG - 1) @(negedge clk);
    #1 chk({nm, "_busy_last_gap"}, 32'(busy_o), 32'(1));
    @(negedge clk);
    #1 chk({nm, "_busy_idle"}, 32'(busy_o), 32'(0));
  endtask

  task automatic check_err(input int len);
    @(negedge clk);
    start_i = 1'b1;
    len_i   = 11'(len);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk($sformatf("err_pulse_len%0d", len), 32'(err_o), 32'(1));
    chk($sformatf("err_valid_busy_len%0d", len), 32'({mac_tx_valid, busy_o}), 32'(0));
    @(negedge clk);
    #1;
    chk($sformatf("err_single_len%0d", len), 32'({err_o, mac_tx_valid, busy_o}), 32'(0));
  endtask

  initial begin
    int base, r0, t0, u0, s0;
    bit got;
    for (int i = 0; i < 2048; i++) begin
      pay_mem[i] = 8'h00;
      vld_mem[i] = 1'b1;
    end
    rst_n   = 1'b0;
    start_i = 1'b0;
    len_i   = '0;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", 32'(outs), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // len=64, payload 0x00..0x3F
    base = slot;
    for (int j = 0; j < 64; j++) pay_mem[base + j] = 8'(j);
    push_frame(64, base, 9999);
    r0 = rdy_cnt; t0 = take_cnt; u0 = und_cnt;
    do_start(64);
    wait_done("len64");
    chk("len64_ready_cycles", 32'(rdy_cnt - r0), 32'(64));
    chk("len64_taken", 32'(take_cnt - t0), 32'(64));
    chk("len64_underruns", 32'(und_cnt - u0), 32'(0));

    // len=1, payload 0xA5, padded to 60
    base = slot;
    pay_mem[base] = 8'hA5;
    push_frame(1, base, 9999);
    r0 = rdy_cnt;
    do_start(1);
    wait_done("len1");
    chk("len1_ready_cycles", 32'(rdy_cnt - r0), 32'(1));

    // len=10 with slots 4 and 5 not valid
    base = slot;
    for (int j = 0; j < 10; j++) pay_mem[base + j] = 8'(8'h10 + j);
    vld_mem[base + 4] = 1'b0;
    vld_mem[base + 5] = 1'b0;
    push_frame(10, base, 9999);
    r0 = rdy_cnt; t0 = take_cnt; u0 = und_cnt;
    do_start(10);
    wait_done("len10");
    chk("len10_ready_cycles", 32'(rdy_cnt - r0), 32'(10));
    chk("len10_taken", 32'(take_cnt - t0), 32'(8));
    chk("len10_underruns", 32'(und_cnt - u0), 32'(2));

    // start held high, len=46: back-to-back frames at minimum spacing
    base = slot;
    for (int j = 0; j < 92; j++) pay_mem[base + j] = 8'(8'h80 + j);
    push_frame(46, base, 9999);
    push_frame(46, base + 46, 9999);
    s0 = sof_t.size();
    r0 = rdy_cnt;
    @(negedge clk);
    start_i = 1'b1;
    len_i   = 11'd46;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (sof_t.size() >= s0 + 2) begin
        got = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    chk("hold_two_sofs", 32'(got), 32'(1));
    if (got) chk("hold_sof_spacing", 32'(sof_t[s0 + 1] - sof_t[s0]), 32'(73));
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (!busy_o && q.size() == 0) break;
    end
    repeat (20) @(negedge clk);
    chk("hold_no_extra_frame", 32'(sof_t.size() - s0), 32'(2));
    chk("hold_queue_drained", 32'(q.size()), 32'(0));
    chk("hold_ready_cycles", 32'(rdy_cnt - r0), 32'(92));

    // illegal lengths
    check_err(0);
    check_err(1501);

    // reset while payload byte 20 of a len=100 frame is on the wire
    base = slot;
    for (int j = 0; j < 100; j++) pay_mem[base + j] = 8'(j * 3);
    push_frame(100, base, 35);
    do_start(100);
    repeat (34) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("midframe_reset_outputs", 32'(outs), 32'(0));
    chk("midframe_bytes_seen", 32'(q.size()), 32'(0));
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("after_release_outputs", 32'(outs), 32'(0));

    // len=50 after reset: 64-byte frame
    base = slot;
    for (int j = 0; j < 50; j++) pay_mem[base + j] = 8'(8'hC0 ^ j);
    push_frame(50, base, 9999);
    r0 = rdy_cnt;
    do_start(50);
    wait_done("len50");
    chk("len50_ready_cycles", 32'(rdy_cnt - r0), 32'(50));

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Transmit-side frame builder for one RGMII port, the counterpart of the receive path that delivers frames as data/valid/sof/eof. It takes a payload length and a byte stream from user logic. It prepends a fixed Ethernet header (destination MAC, source MAC, EtherType), zero-pads short payloads to the 60-byte minimum, and drives the `mac_tx_*` inputs of `mac_rgmii` continuously for the whole frame. The MAC adds preamble/SFD/FCS; this block enforces an inter-frame idle gap.

## Interface
- `DST_MAC`, 48'hFFFF_FFFF_FFFF, destination address, sent MSB byte first
- `SRC_MAC`, 48'h0200_0000_0001, source address, sent MSB byte first
- `ETHERTYPE`, 16'h88B5, type field, sent MSB byte first
- `IFG_CYCLES`, 12, idle cycles inserted after each frame (≥1)

- `mac_tx_clk` in 1: sole clock (`mac_gtx_clk` domain)
- `mac_tx_rstn` in 1: reset, asynchronous, active-low
- `start_i` in 1: frame request, sampled only in IDLE
- `len_i` in 11: payload byte count, sampled with `start_i`; legal 1..1500
- `pld_data_i` in 8: payload byte
- `pld_valid_i` in 1: payload byte valid
- `pld_ready_o` out 1: block takes a payload byte this cycle
- `mac_tx_data` out 8: frame byte to MAC
- `mac_tx_valid` out 1: byte valid, held high for the whole frame
- `mac_tx_sof` out 1: first byte of frame
- `mac_tx_eof` out 1: last byte of frame
- `busy_o` out 1: frame or gap in progress
- `done_o` out 1: one-cycle pulse after last byte
- `err_o` out 1: one-cycle pulse, illegal `len_i` rejected
- `underrun_o` out 1: one-cycle pulse per payload slot filled with 0x00

## Operation
- States: IDLE → HDR (14 bytes) → PLD (`len` bytes) → PAD (46−`len` bytes, skipped if `len`≥46) → GAP (`IFG_CYCLES`) → IDLE.
- IDLE: if `start_i`=1 and 1≤`len_i`≤1500, latch `len_i` and go to HDR. If `start_i`=1 and `len_i` is 0 or >1500, pulse `err_o` next cycle and stay in IDLE. `start_i` outside IDLE is ignored; there is no queueing.
- Frame byte i (0-based): bytes 0–5 are `DST_MAC[47:40]`…`[7:0]`. Bytes 6–11 are `SRC_MAC`. Bytes 12–13 are `ETHERTYPE[15:8]`, `[7:0]`. Bytes 14..13+len are payload. Remaining bytes up to 59 are 0x00.
- Frame length F = 14 + max(len, 46). Byte counter is 11 bits and never wraps (max 1514).
- `pld_ready_o` is high exactly `len` cycles, once per payload slot, whatever `pld_valid_i` does. A slot with `pld_valid_i`=0 emits 0x00 and pulses `underrun_o`. The slot is consumed and the frame length does not change. The source byte is not transferred.
- `mac_tx_valid` never drops mid-frame, since the MAC has no backpressure (`tready` unused).
- All outputs are registered. `pld_ready_o` is decoded from registered state.

## Timing
- Reset (async assert, sync release): all outputs 0, state IDLE, counters 0.
- `start_i` accepted on edge ending cycle N: byte i is on `mac_tx_data` in cycle N+1+i, with `mac_tx_valid`=1 in N+1..N+F.
- `mac_tx_sof`=1 only in N+1; `mac_tx_eof`=1 only in N+F.
- `pld_ready_o`=1 in cycles N+14..N+13+len. Payload byte j is sampled at the end of cycle N+14+j and output in N+15+j. `underrun_o` pulses in the same cycle as the 0x00 byte it replaces.
- `done_o`=1 in N+F+1. GAP runs N+F+1..N+F+`IFG_CYCLES`. IDLE is reached in N+F+`IFG_CYCLES`+1, and that cycle can accept a new start.
- Minimum sof-to-sof spacing is F+`IFG_CYCLES`+1.
- `busy_o`=1 in N+1..N+F+`IFG_CYCLES`.
- Reset mid-frame: outputs clear immediately, giving a truncated frame with no eof. This is accepted; the MAC discards it as a runt.

## Test plan
- len=64, payload 0x00..0x3F, valid always 1 → 78 valid cycles. Bytes 0–13 equal FF×6, 02 00 00 00 00 01, 88 B5; bytes 14–77 equal 0x00..0x3F. sof on the first byte, eof on the 78th, `done_o` the cycle after, no `underrun_o`.
- len=1, payload 0xA5 → 60 valid cycles, byte 14=0xA5, bytes 15–59=0x00, `pld_ready_o` high for exactly 1 cycle.
- len=10, `pld_valid_i` low for payload slots 4 and 5 → bytes 18,19=0x00, two `underrun_o` pulses, frame still 60 bytes, 8 bytes consumed.
- `start_i` held high, len=46 → consecutive sof spaced 73 cycles; `start_i` during busy creates no extra frame.
- len=0 and len=1501 → `err_o` single pulse each, `mac_tx_valid` and `busy_o` stay 0.
- `mac_tx_rstn` low during payload byte 20 of a len=100 frame → all outputs 0 asynchronously. After release, start with len=50 gives a correct 64-byte frame.
